// File: rtl/d_phy_transmitter.sv
// HS-only D-PHY lane transmitter: HS-zero, sync byte, LSB-first payload, optional HS-trail,
// clock-post. Define D_PHY_TRANSMITTER_TRAIL_EN to build the HS-trail state.
module d_phy_transmitter #(
    parameter int unsigned ZERO_BITS    = 16,
    parameter int unsigned TRAIL_BITS   = 8,
    parameter int unsigned POST_PERIODS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       clock_p,
    output logic       data_p,
    output logic       active
);

    localparam int unsigned ZeroCycles  = 2 * ZERO_BITS;
    localparam int unsigned TrailCycles = 2 * TRAIL_BITS;
    localparam int unsigned PostCycles  = 4 * POST_PERIODS;
    localparam int unsigned ByteCycles  = 16;
    localparam int unsigned MaxZb       = (ZeroCycles > ByteCycles) ? ZeroCycles : ByteCycles;
    localparam int unsigned MaxZbt      = (MaxZb > TrailCycles) ? MaxZb : TrailCycles;
    localparam int unsigned MaxCycles   = (MaxZbt > PostCycles) ? MaxZbt : PostCycles;
    localparam int unsigned CntW        = $clog2(MaxCycles);
    localparam logic [7:0]  SyncByte    = 8'hB8;

`ifdef D_PHY_TRANSMITTER_TRAIL_EN
    typedef enum logic [2:0] {StIdle, StZero, StSync, StData, StTrail, StPost} state_e;
`else
    typedef enum logic [2:0] {StIdle, StZero, StSync, StData, StPost} state_e;
`endif

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        n_q, n_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              clock_p_q, clock_p_d;
    logic              data_p_q, data_p_d;
    logic              byte_end;

    assign byte_end = (cnt_q == CntW'(ByteCycles - 1));
    assign clock_p  = clock_p_q;
    assign data_p   = data_p_q;
    assign active   = (state_q != StIdle);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            n_q         <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            clock_p_q   <= 1'b0;
            data_p_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            clock_p_q   <= clock_p_d;
            data_p_q    <= data_p_d;
        end
    end

    // hold_q buffers the next byte; shift_q is the byte on the wire.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CntW'(1);
        n_d         = n_q + 2'd1;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                n_d   = '0;
                if (valid) begin
                    hold_d      = data;
                    hold_full_d = 1'b1;
                    state_d     = StZero;
                end
            end
            StZero: begin
                if (cnt_q == CntW'(ZeroCycles - 1)) begin
                    cnt_d   = '0;
                    state_d = StSync;
                end
            end
            StSync, StData: begin
                if (byte_end) begin
                    cnt_d       = '0;
                    hold_full_d = 1'b0;
                    if (hold_full_q) begin
                        shift_d = hold_q;
                        state_d = StData;
                        if (valid) begin
                            hold_d      = data;
                            hold_full_d = 1'b1;
                        end
                    end else if (valid) begin
                        shift_d = data;
                        state_d = StData;
                    end else begin
`ifdef D_PHY_TRANSMITTER_TRAIL_EN
                        state_d = StTrail;
`else
                        state_d = StPost;
`endif
                    end
                end
            end
`ifdef D_PHY_TRANSMITTER_TRAIL_EN
            StTrail: begin
                if (cnt_q == CntW'(TrailCycles - 1)) begin
                    cnt_d   = '0;
                    state_d = StPost;
                end
            end
`endif
            StPost: begin
                if (cnt_q == CntW'(PostCycles - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs are computed from the next state so they line up with it.
    always_comb begin
        clock_p_d = 1'b0;
        data_p_d  = 1'b0;
        ready     = 1'b0;
        // Bit 1 of (n + 1) gives the 0,1,1,0 lane-clock pattern.
        if (state_d != StIdle) begin
            clock_p_d = n_d[1] ^ n_d[0];
        end
        unique case (state_d)
            StSync:  data_p_d = SyncByte[cnt_d[3:1]];
            StData:  data_p_d = shift_d[cnt_d[3:1]];
`ifdef D_PHY_TRANSMITTER_TRAIL_EN
            StTrail: data_p_d = ~shift_d[7];
`endif
            StPost:  data_p_d = data_p_q;
            default: data_p_d = 1'b0;
        endcase
        ready = !reset && ((state_q == StIdle) ||
                           (((state_q == StSync) || (state_q == StData)) && byte_end));
    end

endmodule

// File: tb/tb_d_phy_transmitter.sv
// Scoreboard bench for d_phy_transmitter: per-cycle expected outputs from a bit-list model,
// plus a lane decoder that recovers bytes from data_p at clock_p edges.
module tb_d_phy_transmitter;

    localparam int unsigned ZB = 16;
    localparam int unsigned TB = 8;
    localparam int unsigned PP = 8;

    logic       clock;
    logic       reset;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       clock_p;
    logic       data_p;
    logic       active;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];   // {active, clock_p, data_p, ready} per cycle
    logic [7:0] byte_q[$];
    int         len_q[$];
    logic [7:0] bq[4];

    d_phy_transmitter #(
        .ZERO_BITS   (ZB),
        .TRAIL_BITS  (TB),
        .POST_PERIODS(PP)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .data   (data),
        .valid  (valid),
        .ready  (ready),
        .clock_p(clock_p),
        .data_p (data_p),
        .active (active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
        end
    endtask

    // One burst: handshake in IDLE, then expected waveform from the bit list.
    task automatic run_burst(input int len, input int gap, input bit late);
        logic       bits[$];
        logic [7:0] sync;
        logic [7:0] b;
        logic       last, c, d, r;
        int         ncyc, fin0, k;
        sync = 8'hB8;
        b    = 8'h00;
        for (int i = 0; i < ZB; i++) bits.push_back(1'b0);
        for (int j = 0; j < 8; j++) bits.push_back(sync[j]);
        for (int m = 0; m < len; m++) begin
            b = bq[m];
            for (int j = 0; j < 8; j++) bits.push_back(b[j]);
        end
`ifdef D_PHY_TRANSMITTER_TRAIL_EN
        for (int i = 0; i < TB; i++) bits.push_back(~b[7]);
`endif
        last = bits[bits.size() - 1];
        ncyc = 2 * bits.size() + 4 * PP;
        fin0 = 2 * ZB + 15;

        next_cycle;
        exp_q.push_back(4'b0001);
        for (int i = 0; i < ncyc; i++) begin
            c = (((i + 1) / 2) % 2) == 1;
            d = (i < 2 * bits.size()) ? bits[i / 2] : last;
            r = (i >= fin0) && (((i - fin0) % 16) == 0) && (i <= fin0 + 16 * len);
            exp_q.push_back({1'b1, c, d, r});
        end
        for (int m = 0; m < len; m++) byte_q.push_back(bq[m]);
        len_q.push_back(len);
        valid = 1'b1;
        data  = bq[0];

        for (int i = 0; i < ncyc; i++) begin
            next_cycle;
            if ((i >= fin0) && (((i - fin0) % 16) == 0) && (i <= fin0 + 16 * len)) begin
                k     = (i - fin0) / 16;
                valid = (k >= 1) && (k < len);
                data  = ((k >= 1) && (k < len)) ? bq[k] : 8'($urandom);
            end else if (late && (i == fin0 + 16 * len + 1)) begin
                valid = 1'b1;
                data  = 8'h77;
            end else begin
                valid = ($urandom_range(3) == 0);
                data  = 8'($urandom);
            end
        end
        for (int g = 0; g < gap; g++) begin
            next_cycle;
            valid = 1'b0;
            exp_q.push_back(4'b0001);
        end
    endtask

    logic [7:0] win = '0;
    logic       prev_clk = 1'b0;
    logic       in_sync = 1'b0;
    int         nb = 0;
    int         bytes_left = 0;

    always @(negedge clock) begin : monitor
        logic [3:0] e;
        logic [7:0] want_b;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle_outputs", {28'd0, active, clock_p, data_p, ready}, {28'd0, e});
        end
        if (active !== 1'b1) begin
            in_sync  = 1'b0;
            prev_clk = 1'b0;
            win      = '0;
            nb       = 0;
        end else begin
            if (clock_p !== prev_clk) begin
                win = {data_p, win[7:1]};
                if (!in_sync) begin
                    if (win == 8'hB8) begin
                        in_sync = 1'b1;
                        nb      = 0;
                        if (len_q.size() > 0) bytes_left = len_q.pop_front();
                        else bytes_left = 0;
                    end
                end else if (bytes_left > 0) begin
                    nb++;
                    if (nb == 8) begin
                        nb = 0;
                        bytes_left--;
                        if (byte_q.size() > 0) want_b = byte_q.pop_front();
                        else want_b = 8'hxx;
                        chk("loopback_byte", {24'd0, win}, {24'd0, want_b});
                    end
                end
            end
            prev_clk = clock_p;
        end
    end

    initial begin
        reset = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        repeat (3) next_cycle;
        valid = 1'b1;
        @(negedge clock);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_outputs", {29'd0, active, clock_p, data_p}, 32'd0);
        next_cycle;
        reset = 1'b0;
        valid = 1'b0;
        @(negedge clock);
        chk("release_ready", {31'd0, ready}, 32'd1);
        chk("release_active", {31'd0, active}, 32'd0);

        bq[0] = 8'h5A;
        run_burst(1, 1, 1'b0);
        bq[0] = 8'h01; bq[1] = 8'hFF; bq[2] = 8'h80;
        run_burst(3, 0, 1'b0);
        bq[0] = 8'h80;
        run_burst(1, 1, 1'b1);
        bq[0] = 8'h77;
        run_burst(1, 0, 1'b0);
        bq[0] = 8'h12; bq[1] = 8'h34;
        run_burst(2, 2, 1'b0);
        for (int t = 0; t < 20; t++) begin
            int len;
            len = $urandom_range(4, 1);
            for (int m = 0; m < 4; m++) bq[m] = 8'($urandom);
            run_burst(len, $urandom_range(2, 0), 1'b0);
        end
        repeat (2) begin
            next_cycle;
            valid = 1'b0;
            exp_q.push_back(4'b0001);
        end

        // Reset during DATA bit 3, with valid also offered while reset is high.
        next_cycle;
        valid = 1'b1;
        data  = 8'hC8;
        repeat (2 * ZB + 23) begin
            next_cycle;
            valid = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        chk("midburst_ready_forced", {31'd0, ready}, 32'd0);
        chk("midburst_active", {31'd0, active}, 32'd1);
        chk("midburst_bit3", {31'd0, data_p}, 32'd1);
        next_cycle;
        valid = 1'b1;
        data  = 8'hAA;
        @(negedge clock);
        chk("midburst_reset_outputs", {29'd0, active, clock_p, data_p}, 32'd0);
        chk("midburst_reset_ready", {31'd0, ready}, 32'd0);
        next_cycle;
        reset = 1'b0;
        valid = 1'b0;
        @(negedge clock);
        chk("post_reset_ready", {31'd0, ready}, 32'd1);
        chk("post_reset_idle", {31'd0, active}, 32'd0);
        next_cycle;
        @(negedge clock);
        chk("reset_wins_no_capture", {31'd0, active}, 32'd0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        chk("bytes_drained", byte_q.size(), 32'd0);
        chk("bursts_drained", len_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/d_phy_transmitter.md
# d_phy_transmitter

HS-only D-PHY lane transmitter, the counterpart of the team's HS-only D-PHY receiver. It turns a stream of payload bytes into one HS burst on a single data lane plus its DDR lane clock: HS-zero, sync byte, LSB-first payload, optional HS-trail, then clock-post. The block sits between the CSI-2 packet builder (byte source) and the LVDS output buffers. One `clock` runs at 4× the lane-clock frequency, so the bit rate is `clock`/2.

## Interface
- `ZERO_BITS`, 16: HS-zero bit times before sync; even, ≥ 2.
- `TRAIL_BITS`, 8: HS-trail bit times; even, ≥ 2. Used only with the trail feature.
- `POST_PERIODS`, 8: lane-clock periods of clock-post, 4 `clock` cycles each; ≥ 1.
- `clock` input 1: single clock. One clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `data` input 8: payload byte.
- `valid` input 1: `data` is offered.
- `ready` output 1: byte accepted this cycle when `valid && ready`.
- `clock_p` output 1: DDR lane clock, registered.
- `data_p` output 1: serial lane data, registered.
- `active` output 1: high from the first HS-zero cycle through the last clock-post cycle.

## Operation
- States: IDLE → ZERO → SYNC → DATA → (TRAIL) → POST → IDLE.
- IDLE:
  - `clock_p`=0, `data_p`=0, `active`=0, `ready`=1.
  - On `valid`, capture `data` into the holding register and go to ZERO.
- Each bit occupies 2 cycles. A 2-bit phase counter `n` starts at 0 on ZERO entry and runs free until IDLE, with `clock_p` = bit 1 of (`n`+1): pattern 0,1,1,0 repeating.
  - Even bits are sampled by the `clock_p` rising edge, odd bits by the falling edge. Each edge falls mid-bit.
- ZERO: `data_p`=0 for `ZERO_BITS` bits.
- SYNC: emit 0xB8 LSB first, so the time order is 0,0,0,1,1,1,0,1.
- DATA: shift the held byte out LSB first, 8 bits (16 cycles).
  - `ready`=1 in the last cycle (cycle 15) of the SYNC byte and of every DATA byte.
  - If `valid` is high in that cycle, the next byte is loaded and streams without a gap.
  - Otherwise, after the current byte completes, go to TRAIL (or POST).
- TRAIL: `data_p` = ~(bit 7 of last byte) for `TRAIL_BITS` bits.
- POST:
  - `clock_p` keeps toggling and `data_p` holds its last value for `POST_PERIODS`×4 cycles.
  - Then IDLE, where `clock_p`=0 and `data_p`=0.
- `ready`=0 in ZERO, TRAIL, POST and all non-final DATA/SYNC cycles. `valid` is ignored then.
- Bit counter widths: sized with $clog2 of the parameters. No wrap occurs within a phase.

## Timing
- Reset (cycle after `reset` high): state IDLE; `clock_p`=0, `data_p`=0, `active`=0.
  - `ready` is forced 0 while `reset` is high and is 1 in the first cycle after release.
- Reset mid-burst: the in-flight byte is dropped; outputs return to reset values on the next edge. No trail or post is emitted.
- Handshake at cycle T in IDLE:
  - ZERO starts at T+1 (`active`=1, `clock_p`=0).
  - SYNC bit 0 appears at T+1+2·`ZERO_BITS`.
  - Byte bit 0 appears at T+17+2·`ZERO_BITS`.
- Byte k+1 bit 0 follows byte k bit 7 immediately: 16 cycles per byte.
- `valid` with `reset` in the same cycle: reset wins, nothing captured.
- Even `ZERO_BITS` and `TRAIL_BITS` keep every sync and payload bit 0 on a rising `clock_p` edge. They also ensure `clock_p`=0 at POST exit.
- Throughput: 1 byte per 16 cycles sustained. Inter-burst gap ≥ 1 IDLE cycle.

## Configuration
- `D_PHY_TRANSMITTER_TRAIL_EN`
  - Defined: TRAIL state present; HS-trail emitted as above.
  - Undefined: TRAIL state and `TRAIL_BITS` logic are compiled out. DATA goes straight to POST, and `data_p` holds bit 7 of the last byte during POST.

## Test plan
- Defaults, one byte 0x5A, trail enabled:
  - `active` rises 1 cycle after handshake; 32 cycles of `data_p`=0.
  - Then bits 0,0,0,1,1,1,0,1; then 0,1,0,1,1,0,1,0.
  - Then 8 trail bits of 1; then 32 post cycles; IDLE with all outputs 0.
- Back-to-back 0x01,0xFF,0x80 with `valid` held high:
  - `ready` pulses exactly at each byte's cycle 15; no gap between bytes.
  - Decoding `data_p` at `clock_p` edges yields B8 01 FF 80.
- `valid` low at a byte-final cycle, high one cycle later: burst ends with trail/post; the late byte is accepted only in the following IDLE.
- `reset` asserted during DATA bit 3: next cycle `clock_p`=0, `data_p`=0, `active`=0, state IDLE; `ready`=1 after release.
- Build without `D_PHY_TRANSMITTER_TRAIL_EN`, byte 0x80: POST begins immediately after bit 7, with `data_p` held 1 for 32 cycles, then 0 in IDLE.
- Loopback into the team's receiver on `clock_p`/`data_p`: enable pulses align with transmitted bytes 0x12, 0x34.
